// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM states, register-file constants, datapath width.
package core_pkg;
  typedef enum logic {RUN, FREEZE} hz_state_e;
  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int         XLEN   = 32;
endpackage

// File: rtl/hazard_ldu_detect.sv
// Combinational load-use compare between the ID instruction's sources and the EX load's rd.
module hazard_ldu_detect
  import core_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       ldu_hazard
);
  logic hit1, hit2;

  assign hit1       = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit2       = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired zero, so a load targeting it never produces a dependency
  assign ldu_hazard = ex_mem_read && (ex_rd != REG_X0) && (hit1 || hit2);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, MEM-stage redirects (with pending capture), load-use bubbles.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int FREEZE_MAX = 64
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_MemRead,
  input  logic            mem_redirect,
  input  logic [XLEN-1:0] mem_target,
  input  logic            mem_busy,
  output logic            pc_we,
  output logic            if_id_we,
  output logic            if_id_flush,
  output logic            id_ex_stall,
  output logic            id_ex_flush,
  output logic            ex_mem_flush,
  output logic            hold_all,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            freeze_timeout
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);
  localparam int FW = $clog2(FREEZE_MAX + 1);

  hz_state_e       state_q, state_d;
  logic            pend_v_q, pend_v_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [FW-1:0]   frz_cnt_q, frz_cnt_d;
  logic            timeout_q, timeout_d;
  logic            ldu_hazard;

  hazard_ldu_detect u_ldu (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_MemRead),
    .ldu_hazard  (ldu_hazard)
  );

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    hold_all     = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = pend_v_q ? pend_pc_q : mem_target;
    state_d      = RUN;
    pend_v_d     = pend_v_q;
    pend_pc_d    = pend_pc_q;
    if (mem_busy) begin
      hold_all = 1'b1;
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      state_d  = FREEZE;
      // The frozen branch stays in MEM, so only its first report is captured
      if (mem_redirect && !pend_v_q) begin
        pend_v_d  = 1'b1;
        pend_pc_d = mem_target;
      end
    end else if (mem_redirect || pend_v_q) begin
      pc_redirect  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      pend_v_d     = 1'b0;
    end else if (ldu_hazard) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_stall = 1'b1;
    end
  end

  // Watchdog: counts consecutive busy cycles from the start of a freeze
  always_comb begin
    frz_cnt_d = '0;
    timeout_d = timeout_q;
    if (mem_busy) begin
      frz_cnt_d = (state_q == FREEZE) ? frz_cnt_q : '0;
      if (frz_cnt_d != FW'(FREEZE_MAX)) frz_cnt_d = frz_cnt_d + 1'b1;
      if (frz_cnt_q == FW'(FREEZE_MAX - 1)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
      frz_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
      frz_cnt_q <= frz_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign freeze_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_ex_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (pc_redirect && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int FMAX = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_MemRead;
  logic        mem_redirect, mem_busy;
  logic [31:0] mem_target;
  logic        pc_we, if_id_we, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush;
  logic        hold_all, pc_redirect, freeze_timeout;
  logic [31:0] redirect_pc;

  hazard_ctrl #(.FREEZE_MAX(FMAX)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .mem_redirect(mem_redirect), .mem_target(mem_target), .mem_busy(mem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .hold_all(hold_all), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .freeze_timeout(freeze_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference state: pending redirect, length of the current busy run, sticky timeout
  bit          m_pv;
  logic [31:0] m_ppc;
  int          m_run;
  bit          m_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input bit r, input bit busy, input bit redir, input logic [31:0] tgt,
                       input bit mr, input logic [4:0] rd, input logic [4:0] s1,
                       input logic [4:0] s2, input bit u1, input bit u2);
    rst = r; mem_busy = busy; mem_redirect = redir; mem_target = tgt;
    ex_MemRead = mr; ex_rd = rd; id_rs1 = s1; id_rs2 = s2; id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  // Check this cycle's outputs against the model, then advance model and clock
  task automatic step();
    bit ldu, redir;
    logic [7:0] exp_ctrl;
    #1;
    ldu   = ex_MemRead && ex_rd != 5'd0 &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    redir = mem_redirect || m_pv;
    // {pc_we, if_id_we, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, hold_all, pc_redirect}
    if (mem_busy)   exp_ctrl = 8'b0000_0010;
    else if (redir) exp_ctrl = 8'b1110_1101;
    else if (ldu)   exp_ctrl = 8'b0001_0000;
    else            exp_ctrl = 8'b1100_0000;
    chk("ctrl", {24'd0, pc_we, if_id_we, if_id_flush, id_ex_stall, id_ex_flush,
                 ex_mem_flush, hold_all, pc_redirect}, {24'd0, exp_ctrl});
    if (!mem_busy && redir) chk("redirect_pc", redirect_pc, m_pv ? m_ppc : mem_target);
    chk("freeze_timeout", {31'd0, freeze_timeout}, {31'd0, m_to});
    if (rst) begin
      m_pv = 0; m_ppc = 0; m_run = 0; m_to = 0;
    end else if (mem_busy) begin
      if (mem_redirect && !m_pv) begin m_pv = 1; m_ppc = mem_target; end
      m_run++;
      if (m_run >= FMAX) m_to = 1;
    end else begin
      m_run = 0;
      if (redir) m_pv = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_pv = 0; m_ppc = 0; m_run = 0; m_to = 0;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();                                           // reset state

    // Load-use: one stall, then bubble in EX clears it; x0 never stalls
    drive(0, 0, 0, 0, 1, 5, 5, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 5, 0, 1, 0); step();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 1, 1); step();
    drive(0, 0, 0, 0, 1, 7, 3, 7, 1, 1); step();      // rs2 match
    drive(0, 0, 0, 0, 1, 7, 7, 3, 0, 1); step();      // match but unused

    // Redirect, and redirect with simultaneous load-use
    drive(0, 0, 1, 32'h40, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 32'h44, 1, 5, 5, 5, 1, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // Redirect captured during freeze; a second report is ignored
    drive(0, 1, 1, 32'h80, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 1, 32'h99, 1, 5, 5, 0, 1, 0); step();
    drive(0, 1, 1, 32'h80, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 32'h12, 1, 5, 5, 0, 1, 0); step();
    drive(0, 0, 0, 0, 1, 5, 5, 0, 1, 0); step();      // pending gone: stall now

    // Watchdog: FMAX-1 busy cycles do not trip, FMAX do
    for (int i = 0; i < FMAX - 1; i++) begin drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < FMAX; i++) begin drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // Reset mid-freeze with a redirect pending
    drive(0, 1, 1, 32'hC0, 0, 0, 0, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0); step();

    // Random traffic with small register indices to provoke matches
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(99) < 2), ($urandom_range(99) < 30), ($urandom_range(99) < 15),
            $urandom, $urandom_range(1), 5'($urandom_range(3)), 5'($urandom_range(3)),
            5'($urandom_range(3)), $urandom_range(1), $urandom_range(1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core.
- Reads decoded ID-stage register indices, the EX-stage control fields at the ID/EX register outputs, and the MEM-stage redirect and busy signals.
- Produces the `stall` and `flush` controls consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Holds the registered state for freeze sequencing, pending redirects and the freeze watchdog.

Parameters:
- FREEZE_MAX, 64: cycles of continuous `mem_busy` before `freeze_timeout` latches.
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk in 1: core clock.
- rst in 1: reset, synchronous, active-high.
- id_rs1 in 5: rs1 of the instruction in ID.
- id_rs2 in 5: rs2 of the instruction in ID.
- id_use_rs1 in 1: ID instruction reads rs1.
- id_use_rs2 in 1: ID instruction reads rs2.
- ex_rd in 5: rd_out of ID/EX.
- ex_MemRead in 1: MemRead_out of ID/EX.
- mem_redirect in 1: taken branch/jal/jalr resolved in MEM.
- mem_target in 32: redirect PC.
- mem_busy in 1: data memory not ready; whole pipeline must hold.
- pc_we out 1: PC write enable.
- if_id_we out 1: IF/ID write enable.
- if_id_flush out 1: load NOP into IF/ID.
- id_ex_stall out 1: ID/EX loads a bubble (MemRead/MemWrite/RegWrite forced 0).
- id_ex_flush out 1: clear ID/EX.
- ex_mem_flush out 1: clear EX/MEM.
- hold_all out 1: all stage registers hold, including ID/EX and MEM/WB.
- pc_redirect out 1: select redirect_pc as next PC.
- redirect_pc out 32: next PC when pc_redirect=1.
- freeze_timeout out 1: sticky watchdog flag.

Behaviour:
- State register takes values RUN and FREEZE.
- Pending register: `pend_v` (1 bit), `pend_pc` (32 bits).
- Watchdog counter: `frz_cnt`, width clog2(FREEZE_MAX+1), saturating.
- Reset, synchronous, takes effect at the next posedge with rst=1:
  - state=RUN, pend_v=0, pend_pc=0, frz_cnt=0, freeze_timeout=0.
  - Asserting rst mid-freeze or with a redirect pending discards both.
- Outputs are combinational from the inputs and registered state, so they take effect in the same cycle. They are evaluated in priority order; the first match wins.
  1. mem_busy=1 (freeze):
     - hold_all=1, pc_we=0, if_id_we=0.
     - All flush and stall outputs are 0; pc_redirect=0.
     - Next state=FREEZE.
     - If mem_redirect=1 and pend_v=0: capture pend_v=1, pend_pc=mem_target.
  2. Redirect, where redirect = mem_redirect | pend_v:
     - pc_redirect=1, pc_we=1.
     - redirect_pc = pend_v ? pend_pc : mem_target.
     - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, if_id_we=1.
     - pend_v clears; next state=RUN.
     - A load-use hazard in the same cycle is ignored, since the ID instruction is squashed.
  3. Load-use:
     - Condition: ex_MemRead=1, ex_rd!=0, and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)).
     - pc_we=0, if_id_we=0, id_ex_stall=1.
     - Exactly one bubble results: next cycle EX holds the bubble (ex_MemRead=0), so the condition clears naturally.
  4. Otherwise: pc_we=1, if_id_we=1, all other controls 0.
- A pending redirect always takes priority over a live mem_redirect. At most one redirect is pending: a second mem_redirect during the same freeze is ignored, because the branch in MEM is frozen and is the same instruction.
- Watchdog:
  - In FREEZE, frz_cnt increments each cycle mem_busy=1; it is cleared when mem_busy=0.
  - freeze_timeout sets when frz_cnt==FREEZE_MAX-1 with mem_busy=1.
  - freeze_timeout stays set until rst.
- Register x0 never causes a stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, the block adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W]:
  - stall_cnt increments on each load-use bubble cycle.
  - flush_cnt increments on each redirect cycle.
  - Both saturate at all-ones and reset to 0.
- When not defined, these ports and registers are absent.

Decomposition:
- Shared package `core_pkg`:
  - State enum (RUN, FREEZE).
  - REG_X0 constant (5'd0).
  - XLEN=32.
- One sub-module, `hazard_ldu_detect`: purely combinational load-use compare. The FSM, pending register and watchdog stay in the top module.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → pc_we=0, if_id_we=0, id_ex_stall=1 for exactly one cycle. With ex_rd=0 instead → no stall.
- Redirect: mem_redirect=1, mem_target=0x0000_0040 → same cycle pc_redirect=1, redirect_pc=0x40, all three flushes=1.
- Redirect during freeze: mem_busy=1 for 3 cycles with mem_redirect=1, mem_target=0x80; then mem_busy=0 with mem_redirect=0 → hold_all=1 for 3 cycles, then one cycle of pc_redirect=1, redirect_pc=0x80; pend_v clears afterwards.
- Simultaneous redirect and load-use hazard → flushes only, id_ex_stall=0.
- Watchdog: mem_busy held for FREEZE_MAX=64 cycles → freeze_timeout=1 after cycle 64 and stays 1 after mem_busy drops; rst clears it.
- Reset mid-freeze with pend_v=1 → after one posedge with rst=1: pc_we=1, pc_redirect=0, no pending redirect applied.
